// File: rtl/boot_pkg.sv
// Shared encodings for the UART boot loader: frame constants and FSM state types.
package boot_pkg;

  localparam logic [7:0]  MAGIC    = 8'hA5;
  localparam int unsigned LenW     = 16;
  localparam int unsigned ByteIdxW = 2;

  typedef enum logic [2:0] {
    BootIdle,
    BootLenLo,
    BootLenHi,
    BootData,
    BootCheck,
    BootRun,
    BootError
  } boot_state_e;

  typedef enum logic [1:0] {
    RxIdle,
    RxStart,
    RxData,
    RxStop
  } rx_state_e;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchronizer, mid-bit sampling, one-cycle byte/frame-error pulses.
module uart_rx
  import boot_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] FullM1 = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] HalfM1 = CntW'(CLKS_PER_BIT / 2 - 1);

  rx_state_e       rx_state_q, rx_state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            valid_q, valid_d;
  logic            ferr_q, ferr_d;
  logic            rx_meta_q, rx_sync_q, rx_prev_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RxIdle;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      rx_meta_q  <= rx;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
      rx_state_q <= rx_state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    valid_d    = 1'b0;
    ferr_d     = 1'b0;
    unique case (rx_state_q)
      RxIdle: begin
        if (rx_prev_q && !rx_sync_q) begin
          rx_state_d = RxStart;
          cnt_d      = '0;
        end
      end
      RxStart: begin
        if (cnt_q == HalfM1) begin
          // A glitch that is gone by mid-start returns to idle without any report.
          cnt_d      = '0;
          bit_idx_d  = '0;
          rx_state_d = rx_sync_q ? RxIdle : RxData;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RxData: begin
        if (cnt_q == FullM1) begin
          cnt_d   = '0;
          shift_d = {rx_sync_q, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            rx_state_d = RxStop;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RxStop: begin
        if (cnt_q == FullM1) begin
          cnt_d      = '0;
          rx_state_d = RxIdle;
          valid_d    = rx_sync_q;
          ferr_d     = !rx_sync_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: rx_state_d = RxIdle;
    endcase
  end

  assign byte_valid = valid_q;
  assign byte_data  = shift_q;
  assign frame_err  = ferr_q;

endmodule

// File: rtl/uart_boot_loader.sv
// Receives a framed program image over UART, writes it into instruction memory and
// holds the core in reset until a checksum-valid image is stored.
module uart_boot_loader
  import boot_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT   = 434,
  parameter int unsigned TIMEOUT_CYCLES = 5_000_000,
  parameter int unsigned MAX_WORDS      = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rx,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_data,
  output logic        cpu_hold,
  output logic        done,
  output logic        error
);

  localparam int unsigned IdxW = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
  localparam int unsigned ToW  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [ToW-1:0] ToMax = ToW'(TIMEOUT_CYCLES - 1);

  logic       byte_valid;
  logic [7:0] byte_data;
  logic       frame_err;

  uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart_rx (
    .clock     (clock),
    .reset     (reset),
    .rx        (rx),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .frame_err (frame_err)
  );

  boot_state_e         state_q, state_d;
  logic [LenW-1:0]     count_q, count_d;
  logic [IdxW-1:0]     word_idx_q, word_idx_d;
  logic [ByteIdxW-1:0] byte_idx_q, byte_idx_d;
  logic [7:0]          csum_q, csum_d;
  logic [23:0]         word_q, word_d;
  logic [ToW-1:0]      to_cnt_q, to_cnt_d;
  logic                we_q, we_d;
  logic [31:0]         addr_q, addr_d;
  logic [31:0]         data_q, data_d;
  logic                hold_q, hold_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic            in_frame;
  logic [LenW-1:0] len_full;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= BootIdle;
      count_q    <= '0;
      word_idx_q <= '0;
      byte_idx_q <= '0;
      csum_q     <= '0;
      word_q     <= '0;
      to_cnt_q   <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      hold_q     <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      word_idx_q <= word_idx_d;
      byte_idx_q <= byte_idx_d;
      csum_q     <= csum_d;
      word_q     <= word_d;
      to_cnt_q   <= to_cnt_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      hold_q     <= hold_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    word_idx_d = word_idx_q;
    byte_idx_d = byte_idx_q;
    csum_d     = csum_q;
    word_d     = word_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    data_d     = data_q;
    hold_d     = hold_q;
    done_d     = done_q;
    err_d      = err_q;
    len_full   = {byte_data, count_q[7:0]};

    in_frame = (state_q == BootLenLo) || (state_q == BootLenHi) ||
               (state_q == BootData)  || (state_q == BootCheck);
    to_cnt_d = (byte_valid || !in_frame) ? '0 : to_cnt_q + 1'b1;

    unique case (state_q)
      BootIdle, BootRun: begin
        if (byte_valid && (byte_data == MAGIC)) begin
          state_d = BootLenLo;
          hold_d  = 1'b1;
          done_d  = 1'b0;
          err_d   = 1'b0;
        end
      end
      BootLenLo: begin
        if (byte_valid) begin
          count_d[7:0] = byte_data;
          state_d      = BootLenHi;
        end
      end
      BootLenHi: begin
        if (byte_valid) begin
          count_d    = len_full;
          word_idx_d = '0;
          byte_idx_d = '0;
          csum_d     = '0;
          if (32'(len_full) > MAX_WORDS) begin
            state_d = BootError;
          end else if (len_full == '0) begin
            state_d = BootCheck;
          end else begin
            state_d = BootData;
          end
        end
      end
      BootData: begin
        if (byte_valid) begin
          csum_d     = csum_q ^ byte_data;
          byte_idx_d = byte_idx_q + 1'b1;
          case (byte_idx_q)
            2'd0: word_d[7:0]   = byte_data;
            2'd1: word_d[15:8]  = byte_data;
            2'd2: word_d[23:16] = byte_data;
            default: begin
              we_d       = 1'b1;
              addr_d     = 32'({word_idx_q, 2'b00});
              data_d     = {byte_data, word_q};
              word_idx_d = word_idx_q + 1'b1;
              if (LenW'(word_idx_q) == (count_q - 1'b1)) begin
                state_d = BootCheck;
              end
            end
          endcase
        end
      end
      BootCheck: begin
        if (byte_valid) begin
          if (byte_data == csum_q) begin
            state_d = BootRun;
            hold_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = BootError;
          end
        end
      end
      BootError: state_d = BootIdle;
      default:   state_d = BootIdle;
    endcase

    // A received byte beats a timeout landing in the same cycle.
    if (in_frame && (frame_err || (!byte_valid && (to_cnt_q == ToMax)))) begin
      state_d = BootError;
    end

    if ((state_d == BootError) && (state_q != BootError)) begin
      err_d  = 1'b1;
      hold_d = 1'b1;
      done_d = 1'b0;
    end
  end

  assign imem_we   = we_q;
  assign imem_addr = addr_q;
  assign imem_data = data_q;
  assign cpu_hold  = hold_q;
  assign done      = done_q;
  assign error     = err_q;

endmodule

// File: tb/tb_uart_boot_loader.sv
// Directed bench for uart_boot_loader: drives UART frames and checks writes and status flags.
module tb_uart_boot_loader;

  localparam int unsigned Cpb     = 8;
  localparam int unsigned Timeout = 300;
  localparam int unsigned MaxW    = 1024;

  logic        clk;
  logic        rst_n;
  logic        rx;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        cpu_hold;
  logic        done;
  logic        error;

  int n_vec;
  int n_miss;

  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  int          we_run;
  int          we_max_run;

  uart_boot_loader #(
    .CLKS_PER_BIT  (Cpb),
    .TIMEOUT_CYCLES(Timeout),
    .MAX_WORDS     (MaxW)
  ) dut (
    .clock    (clk),
    .reset    (rst_n),
    .rx       (rx),
    .imem_we  (imem_we),
    .imem_addr(imem_addr),
    .imem_data(imem_data),
    .cpu_hold (cpu_hold),
    .done     (done),
    .error    (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    we_run     = 0;
    we_max_run = 0;
    forever begin
      @(negedge clk);
      if (imem_we) begin
        we_run++;
        wr_addr.push_back(imem_addr);
        wr_data.push_back(imem_data);
      end else begin
        we_run = 0;
      end
      if (we_run > we_max_run) we_max_run = we_run;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic hold_bit(input logic b);
    #1 rx = b;
    repeat (Cpb) @(posedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
    @(posedge clk);
    hold_bit(1'b0);
    for (int i = 0; i < 8; i++) hold_bit(b[i]);
    hold_bit(stop);
    hold_bit(1'b1);
    hold_bit(1'b1);
  endtask

  task automatic send_frame(input logic [7:0] f[$]);
    foreach (f[i]) send_byte(f[i]);
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
  endtask

  task automatic check_flags(input string tag, input logic d, input logic h, input logic e);
    check_eq({tag, "_done"}, 32'(done), 32'(d));
    check_eq({tag, "_hold"}, 32'(cpu_hold), 32'(h));
    check_eq({tag, "_err"}, 32'(error), 32'(e));
  endtask

  logic [7:0] good[$];
  logic [7:0] bad[$];

  initial begin
    n_vec  = 0;
    n_miss = 0;
    rx     = 1'b1;
    rst_n  = 1'b0;
    good = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
             8'h93, 8'h00, 8'h10, 8'h00, 8'h90};
    bad  = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
             8'h93, 8'h00, 8'h10, 8'h00, 8'h91};
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_we", 32'(imem_we), 32'd0);
    check_eq("rst_addr", imem_addr, 32'h0);
    check_eq("rst_data", imem_data, 32'h0);
    check_flags("rst", 1'b0, 1'b1, 1'b0);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);

    // Two-word load
    clear_log();
    send_frame(good);
    check_eq("two_nwr", 32'(wr_addr.size()), 32'd2);
    if (wr_addr.size() == 2) begin
      check_eq("two_a0", wr_addr[0], 32'h0);
      check_eq("two_d0", wr_data[0], 32'h0000_0013);
      check_eq("two_a1", wr_addr[1], 32'h4);
      check_eq("two_d1", wr_data[1], 32'h0010_0093);
    end
    check_eq("two_addr_hold", imem_addr, 32'h4);
    check_eq("two_data_hold", imem_data, 32'h0010_0093);
    check_eq("we_width", 32'(we_max_run), 32'd1);
    check_flags("two", 1'b1, 1'b0, 1'b0);

    // Bad checksum (reload from RUN)
    clear_log();
    send_frame(bad);
    check_eq("bad_nwr", 32'(wr_addr.size()), 32'd2);
    check_flags("bad", 1'b0, 1'b1, 1'b1);

    // Empty image
    clear_log();
    send_frame('{8'hA5, 8'h00, 8'h00, 8'h00});
    check_eq("empty_nwr", 32'(wr_addr.size()), 32'd0);
    check_flags("empty", 1'b1, 1'b0, 1'b0);

    // Oversized image: N = 1025
    clear_log();
    send_frame('{8'hA5, 8'h01, 8'h04});
    check_flags("big", 1'b0, 1'b1, 1'b1);
    send_frame('{8'h13, 8'h00, 8'h00, 8'h00, 8'h00});
    check_eq("big_nwr", 32'(wr_addr.size()), 32'd0);
    check_flags("big_after", 1'b0, 1'b1, 1'b1);

    // Framing error on the 3rd data byte
    clear_log();
    send_frame('{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22});
    check_eq("ferr_pre", 32'(error), 32'd0);
    send_byte(8'h33, 1'b0);
    send_byte(8'h44);
    check_eq("ferr_nwr", 32'(wr_addr.size()), 32'd0);
    check_flags("ferr", 1'b0, 1'b1, 1'b1);

    // Timeout after 5 data bytes, then reload
    clear_log();
    send_frame('{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93});
    check_eq("to_pre", 32'(error), 32'd0);
    repeat (Timeout - 100) @(posedge clk);
    #1;
    check_eq("to_early", 32'(error), 32'd0);
    repeat (150) @(posedge clk);
    #1;
    check_eq("to_nwr", 32'(wr_addr.size()), 32'd1);
    check_flags("to", 1'b0, 1'b1, 1'b1);
    clear_log();
    send_byte(8'hA5);
    check_eq("reload_err_clr", 32'(error), 32'd0);
    send_frame(good[1:$]);
    check_eq("reload_nwr", 32'(wr_addr.size()), 32'd2);
    if (wr_addr.size() == 2) check_eq("reload_d1", wr_data[1], 32'h0010_0093);
    check_flags("reload", 1'b1, 1'b0, 1'b0);

    // Asynchronous reset mid-DATA
    send_frame('{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00});
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check_eq("arst_we", 32'(imem_we), 32'd0);
    check_eq("arst_addr", imem_addr, 32'h0);
    check_eq("arst_data", imem_data, 32'h0);
    check_flags("arst", 1'b0, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    clear_log();
    send_frame(good);
    check_eq("post_rst_nwr", 32'(wr_addr.size()), 32'd2);
    check_flags("post_rst", 1'b1, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
